// File: rtl/ex_stage.sv
// MIPS-style R-type execute stage: single-cycle ALU, HI/LO register pair,
// one-cycle multiplier and a 32-cycle restoring divider that stalls upstream.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic        write_reg_en_in,
    input  logic [4:0]  write_reg_addr_in,
    output logic [31:0] result,
    output logic        write_reg_en_out,
    output logic [4:0]  write_reg_addr_out,
    output logic        stall_request
);

    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04, F_SRLV = 6'h06, F_SRAV = 6'h07;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_t;

    div_state_t  state_r, state_s;
    logic [31:0] hi_r, lo_r;
    logic [4:0]  cnt_r;
    logic [31:0] rem_r, quo_r, dvs_r;
    logic        neg_q_r, neg_r_r;

    logic        is_div_s, is_signed_div_s, is_hilo_wr_s;
    logic [32:0] partial_s;
    logic        qbit_s;
    logic [31:0] rem_nxt_s, quo_nxt_s, quo_fin_s, rem_fin_s;
    logic signed [63:0] sprod_s;
    logic [63:0] uprod_s;

    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
        magnitude = (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    assign is_div_s        = (funct == F_DIV) || (funct == F_DIVU);
    assign is_signed_div_s = (funct == F_DIV);
    assign is_hilo_wr_s    = (funct == F_MTHI) || (funct == F_MTLO) ||
                             (funct == F_MULT) || (funct == F_MULTU);

    assign sprod_s = $signed(operand_1) * $signed(operand_2);
    assign uprod_s = {32'd0, operand_1} * {32'd0, operand_2};

    // One restoring step: shift next dividend bit into the partial remainder, subtract if it fits
    assign partial_s = {rem_r, quo_r[31]};
    assign qbit_s    = (partial_s >= {1'b0, dvs_r});
    assign rem_nxt_s = qbit_s ? (partial_s[31:0] - dvs_r) : partial_s[31:0];
    assign quo_nxt_s = {quo_r[30:0], qbit_s};
    assign quo_fin_s = neg_q_r ? (32'd0 - quo_nxt_s) : quo_nxt_s;
    assign rem_fin_s = neg_r_r ? (32'd0 - rem_nxt_s) : rem_nxt_s;

    assign write_reg_addr_out = write_reg_addr_in;

    // ALU result mux
    always_comb begin
        result = 32'd0;
        case (funct)
            F_SLL:   result = operand_2 << shamt;
            F_SRL:   result = operand_2 >> shamt;
            F_SRA:   result = $unsigned($signed(operand_2) >>> shamt);
            F_SLLV:  result = operand_2 << operand_1[4:0];
            F_SRLV:  result = operand_2 >> operand_1[4:0];
            F_SRAV:  result = $unsigned($signed(operand_2) >>> operand_1[4:0]);
            F_MFHI:  result = hi_r;
            F_MFLO:  result = lo_r;
            F_ADDU:  result = operand_1 + operand_2;
            F_SUBU:  result = operand_1 - operand_2;
            F_AND:   result = operand_1 & operand_2;
            F_OR:    result = operand_1 | operand_2;
            F_XOR:   result = operand_1 ^ operand_2;
            F_NOR:   result = ~(operand_1 | operand_2);
            F_SLT:   result = {31'd0, ($signed(operand_1) < $signed(operand_2))};
            F_SLTU:  result = {31'd0, (operand_1 < operand_2)};
            default: result = 32'd0;
        endcase
    end

    // Divider next-state, stall and write-enable qualification
    always_comb begin
        state_s          = state_r;
        stall_request    = 1'b0;
        write_reg_en_out = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_div_s) begin
                    state_s       = BUSY;
                    stall_request = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                stall_request = 1'b1;
                if (cnt_r == 5'd31) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
        if (rst) begin
            stall_request = 1'b0;
        end else begin
            write_reg_en_out = write_reg_en_in && !stall_request && (state_r != DONE) &&
                               !is_div_s && !is_hilo_wr_s;
        end
    end

    // State, divider datapath and HI/LO registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            dvs_r   <= 32'd0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (is_div_s) begin
                        cnt_r   <= 5'd0;
                        rem_r   <= 32'd0;
                        quo_r   <= magnitude(operand_1, is_signed_div_s);
                        dvs_r   <= magnitude(operand_2, is_signed_div_s);
                        neg_q_r <= is_signed_div_s && (operand_1[31] ^ operand_2[31]);
                        neg_r_r <= is_signed_div_s && operand_1[31];
                    end else if (funct == F_MTHI) begin
                        hi_r <= operand_1;
                    end else if (funct == F_MTLO) begin
                        lo_r <= operand_1;
                    end else if (funct == F_MULT) begin
                        hi_r <= sprod_s[63:32];
                        lo_r <= sprod_s[31:0];
                    end else if (funct == F_MULTU) begin
                        hi_r <= uprod_s[63:32];
                        lo_r <= uprod_s[31:0];
                    end
                end
                BUSY: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        hi_r <= rem_fin_s;
                        lo_r <= quo_fin_s;
                    end
                end
                DONE:    cnt_r <= 5'd0;
                default: cnt_r <= 5'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ex_stage;

    localparam logic [5:0] F_SLL  = 6'h00, F_SRA  = 6'h03, F_SRLV = 6'h06;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR  = 6'h26, F_NOR = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A, F_SLTU = 6'h2B, F_BAD = 6'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  funct = 6'h00;
    logic [4:0]  shamt = 5'd0;
    logic [31:0] operand_1 = 32'd0, operand_2 = 32'd0;
    logic        write_reg_en_in = 1'b0;
    logic [4:0]  write_reg_addr_in = 5'd0;
    logic [31:0] result;
    logic        write_reg_en_out;
    logic [4:0]  write_reg_addr_out;
    logic        stall_request;

    ex_stage dut (
        .clk(clk), .rst(rst), .funct(funct), .shamt(shamt),
        .operand_1(operand_1), .operand_2(operand_2),
        .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
        .result(result), .write_reg_en_out(write_reg_en_out),
        .write_reg_addr_out(write_reg_addr_out), .stall_request(stall_request)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] res;
        logic        stall;
        logic        wen;
        logic [4:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic [4:0] addr_v = 5'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every expectation tagged for the current cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp({e.tag, ".result"}, result, e.res);
            cmp({e.tag, ".stall"},  {31'd0, stall_request}, {31'd0, e.stall});
            cmp({e.tag, ".wen"},    {31'd0, write_reg_en_out}, {31'd0, e.wen});
            cmp({e.tag, ".addr"},   {27'd0, write_reg_addr_out}, {27'd0, e.addr});
        end
    end

    task automatic step(input string tag, input logic r, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] eres, input logic estall, input logic ewen);
        exp_t e;
        @(posedge clk);
        #1;
        addr_v            = addr_v + 5'd1;
        rst               = r;
        funct             = f;
        operand_1         = a;
        operand_2         = b;
        shamt             = sh;
        write_reg_en_in   = 1'b1;
        write_reg_addr_in = addr_v;
        e.cyc   = cyc;
        e.tag   = tag;
        e.res   = eres;
        e.stall = estall;
        e.wen   = ewen;
        e.addr  = addr_v;
        exp_q.push_back(e);
    endtask

    // Full divide: issue + 32 BUSY cycles stalled, then DONE unstalled; funct held throughout
    task automatic divide(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 33; i++) step({tag, ".busy"}, 1'b0, f, a, b, 5'd0, 32'd0, 1'b1, 1'b0);
        step({tag, ".done"}, 1'b0, f, a, b, 5'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with a divide request: no stall, no write
        step("rst0", 1'b1, F_DIV, 32'd7, 32'd2, 5'd0, 32'd0, 1'b0, 1'b0);
        step("rst1", 1'b1, F_DIV, 32'd7, 32'd2, 5'd0, 32'd0, 1'b0, 1'b0);
        step("hi0",  1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        step("lo0",  1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);

        step("addu_wrap", 1'b0, F_ADDU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0000_0000, 1'b0, 1'b1);
        step("slt",       1'b0, F_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, 1'b1);
        step("sltu",      1'b0, F_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b0, 1'b1);
        step("sra",       1'b0, F_SRA,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b1);
        step("srlv",      1'b0, F_SRLV, 32'd36, 32'h8000_0000, 5'd0, 32'h0800_0000, 1'b0, 1'b1);
        step("sll31",     1'b0, F_SLL,  32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0, 1'b1);
        step("subu",      1'b0, F_SUBU, 32'd0, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step("and",       1'b0, F_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h00F0_1200, 1'b0, 1'b1);
        step("or",        1'b0, F_OR,   32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'hFFF0_FF34, 1'b0, 1'b1);
        step("xor",       1'b0, F_XOR,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'hFF00_ED34, 1'b0, 1'b1);
        step("nor",       1'b0, F_NOR,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0, 32'h000F_00CB, 1'b0, 1'b1);

        // MULT -2*3 = -6, then read back with no stall
        step("mult",      1'b0, F_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'd0, 1'b0, 1'b0);
        step("mult.hi",   1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step("mult.lo",   1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFA, 1'b0, 1'b1);
        step("multu",     1'b0, F_MULTU, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'd0, 1'b0, 1'b0);
        step("multu.hi",  1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'h0000_0002, 1'b0, 1'b1);
        step("bad",       1'b0, F_BAD,  32'h1111_1111, 32'h2222_2222, 5'd3, 32'd0, 1'b0, 1'b1);
        step("bad.lo",    1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFA, 1'b0, 1'b1);
        step("mthi",      1'b0, F_MTHI, 32'h1234_5678, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        step("mthi.hi",   1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'h1234_5678, 1'b0, 1'b1);
        step("mtlo",      1'b0, F_MTLO, 32'hCAFE_BABE, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0);
        step("mtlo.lo",   1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'hCAFE_BABE, 1'b0, 1'b1);

        // DIV -7/2 -> q=-3, r=-1
        divide("div", F_DIV, 32'hFFFF_FFF9, 32'd2);
        step("div.lo", 1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b1);
        step("div.hi", 1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // DIVU by zero
        divide("divz", F_DIVU, 32'd5, 32'd0);
        step("divz.lo", 1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        step("divz.hi", 1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'd5, 1'b0, 1'b1);

        // Reset in BUSY cycle 10 abandons the divide and clears HI/LO
        for (int i = 0; i < 10; i++)
            step("abort.busy", 1'b0, F_DIVU, 32'd100, 32'd7, 5'd0, 32'd0, 1'b1, 1'b0);
        step("abort.rst", 1'b1, F_DIVU, 32'd100, 32'd7, 5'd0, 32'd0, 1'b0, 1'b0);
        step("abort.hi",  1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        step("abort.lo",  1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b1);
        divide("divu", F_DIVU, 32'd100, 32'd7);
        step("divu.lo", 1'b0, F_MFLO, 32'd0, 32'd0, 5'd0, 32'd14, 1'b0, 1'b1);
        step("divu.hi", 1'b0, F_MFHI, 32'd0, 32'd0, 5'd0, 32'd2, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        cmp("scoreboard.drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
